// File: rtl/alu_arbiter_if.sv
// Request/response bus between NUM_REQ requesters and the shared-ALU arbiter.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high; the
// sender holds valid and payload stable until then, and ready may depend combinationally on valid.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int OP_W    = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][OP_W-1:0] req_op;
  logic [NUM_REQ-1:0][31:0]     req_a;
  logic [NUM_REQ-1:0][31:0]     req_b;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [31:0]                  rsp_res;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NUM_REQ requesters.
// IDLE accepts one operation, EXEC lets the ALU sample it, RESP returns the result.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int OP_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_res,
  output logic             busy,
  output logic [31:0]      op_count,
  output logic [1:0]       state_dbg
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  logic             accept;
  logic             complete;
  logic [OP_W-1:0]  op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      op_count_q;
  int               cand;

  // Scan upward from the slot after the last grant, wrapping, and take the first valid.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && bus.req_valid[cand_idx]) begin
        winner = cand_idx;
        found  = 1'b1;
      end
    end
  end

  // rst_n gates acceptance so a requester holding valid through reset sees no ready.
  assign accept   = rst_n && (state_q == S_IDLE) && found;
  assign complete = (state_q == S_RESP) && bus.rsp_ready[owner_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (complete) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q         <= bus.req_op[winner];
        a_q          <= bus.req_a[winner];
        b_q          <= bus.req_b[winner];
        owner_q      <= winner;
        last_grant_q <= winner;
      end
      if (complete) begin
        op_count_q <= op_count_q + 32'd1;
      end
    end
  end

  // The ALU sees only the holding registers, so its result stays stable through RESP.
  assign alu_op        = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign bus.req_ready = accept ? (ONE << winner) : '0;
  assign bus.rsp_valid = (state_q == S_RESP) ? (ONE << owner_q) : '0;
  assign bus.rsp_res   = alu_res;
  assign busy          = (state_q != S_IDLE);
  assign op_count      = op_count_q;
  assign state_dbg     = state_q;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single registered ALU (one-cycle result latency) between NUM_REQ requesters, e.g. the execute stage and the branch unit. Requesters use a valid/ready request channel and a valid/ready response channel. A three-state sequencer accepts one operation at a time, holds its operands stable on the ALU inputs, and returns the registered ALU result to the granted requester. Arbitration is round-robin.

Parameters:
NUM_REQ, 2, number of requesters (2..8); sets req/rsp array sizes and grant index width IDX_W = $clog2(NUM_REQ).

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  requester i has an operation pending.
req_ready  output  NUM_REQ  one-hot; the operation of requester i is accepted this cycle.
req_op  input  NUM_REQ x op_t  per-requester ALU operation.
req_a  input  NUM_REQ x 32  per-requester operand a, signed.
req_b  input  NUM_REQ x 32  per-requester operand b, signed.
rsp_valid  output  NUM_REQ  one-hot; the result for requester i is presented.
rsp_ready  input  NUM_REQ  requester i takes the result.
rsp_res  output  32  result, shared by all requesters; qualified by rsp_valid.
alu_op  output  op_t  operation driven to the ALU.
alu_a  output  32  operand a driven to the ALU.
alu_b  output  32  operand b driven to the ALU.
alu_res  input  32  registered ALU result.
busy  output  1  high whenever state != IDLE.
op_count  output  32  number of completed responses; wraps modulo 2^32.

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Values after reset:
  - req_ready = 0, rsp_valid = 0, busy = 0, op_count = 0.
  - Holding registers (op/a/b) = 0, so alu_op/alu_a/alu_b = 0 (op_t value 0).
  - owner = 0; last_grant = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - If any req_valid is set, the winner w is the first set bit scanning upward, with wrap, from last_grant+1.
  - req_ready[w] = 1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the clock edge: latch req_op[w]/req_a[w]/req_b[w] into the holding registers; owner <= w; last_grant <= w; go to EXEC.
  - If no req_valid is set: stay in IDLE, all req_ready = 0.
- req_ready is 0 in EXEC and RESP. Requesters hold valid and data until they see ready.
- alu_op/alu_a/alu_b are driven only from the holding registers, never combinationally from req_*. They stay stable from EXEC until the next acceptance.
- EXEC: the ALU samples the held operands at the end of this cycle. Go to RESP unconditionally.
- RESP:
  - rsp_valid[owner] = 1 and rsp_res = alu_res. This is stable because the operands are unchanged.
  - When rsp_ready[owner] = 1: op_count increments and state goes to IDLE.
  - Otherwise stay in RESP and keep rsp_res stable; backpressure is indefinite.
  - rsp_ready bits of non-owners are ignored.
- Latency: acceptance at cycle T, rsp_valid at T+2. Best-case throughput is one operation per 3 cycles; there is no acceptance in RESP.
- Fairness: a requester that keeps req_valid asserted is granted within NUM_REQ acceptances.
- A requester that drops req_valid while not granted is legal and is simply skipped.
- op values are forwarded unmodified; undefined encodings get whatever the ALU produces.
- op_count wraps from 0xFFFFFFFF to 0 silently.
- Reset asserted mid-operation, in any state:
  - Immediately: state = IDLE, rsp_valid = 0, req_ready = 0, holding registers cleared.
  - The in-flight result is discarded and not counted.
- Exactly one rsp_valid bit can be set at a time, and only in RESP.

Test Plan:
- Single request: req0 ADD a=5, b=7 held valid from cycle 0 -> req_ready[0]=1 in cycle 0; rsp_valid[0]=1, rsp_res=12 in cycle 2; rsp_ready[0]=1 in cycle 2 -> op_count=1, IDLE in cycle 3.
- Contention, NUM_REQ=2: both valid from reset; req0 SUB 10-3, req1 SLL 1<<4 -> req0 granted first with rsp_res=7; req1 granted next with rsp_res=16; then req0 again (grants alternate 0,1,0,1).
- Backpressure: req1 LTU a=-1, b=1 with rsp_ready low for 5 cycles -> rsp_valid[1] and rsp_res=0 held for 5 cycles; no req_ready during them; completes on the cycle rsp_ready rises.
- Signed path: req0 SRA a=0x80000000, b=4 -> rsp_res=0xF8000000; req0 LT a=-2, b=1 -> rsp_res=1.
- Reset mid-operation: rst_n low during EXEC of ADD 1+1 -> outputs return to reset values immediately; after release there is no rsp_valid until a new request; op_count=0.
- op_count wrap: preload by running requests until op_count=0xFFFFFFFF (or force it) and complete one more -> op_count=0.
